// File: rtl/mdsa_phase_sequencer.sv
// Phase sequencer for a multi-phase sort network: steps through NUM_PHASES
// phases of PHASE_LEN cycles, drains for one more interval, then pulses output_enable.
module mdsa_phase_sequencer #(
   parameter int DIR_W      = 8,
   parameter int NUM_PHASES = 6,
   parameter int PHASE_LEN  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             descend,
   input  logic             abort,
   output logic [DIR_W-1:0] direction,
   output logic [3:0]       phase,
   output logic             ready,
   output logic             busy,
   output logic             trans,
   output logic             output_enable
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST   = 8'(PHASE_LEN - 1);
   localparam logic [3:0] PHASE_LAST = 4'(NUM_PHASES);

   state_t           state_r, state_s;
   logic [7:0]       cnt_r, cnt_s;
   logic [3:0]       phase_s;
   logic             desc_r, desc_s;
   logic             trans_s, oe_s, ready_s;
   logic [DIR_W-1:0] dir_s;

   // Phase 2 mod 4 selects the 0101.. lane pattern, phase 0 mod 4 (nonzero) selects 1010..
   function automatic logic [DIR_W-1:0] base_pattern(input logic [3:0] p);
      logic [DIR_W-1:0] pat;
      pat = {DIR_W{1'b0}};
      for (int i = 0; i < DIR_W; i++) begin
         if (p[1:0] == 2'd2) begin
            pat[i] = (i % 2 == 0);
         end else if (p[1:0] == 2'd0 && p != 4'd0) begin
            pat[i] = (i % 2 == 1);
         end else begin
            pat[i] = 1'b0;
         end
      end
      return pat;
   endfunction

   // Next-state, counter and pulse decode; abort outranks en/start.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      phase_s = phase;
      desc_s  = desc_r;
      trans_s = 1'b0;
      oe_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && en && !abort) begin
               state_s = RUN;
               phase_s = 4'd1;
               cnt_s   = 8'd0;
               desc_s  = descend;
               trans_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_s = IDLE;
               phase_s = 4'd0;
               cnt_s   = 8'd0;
            end else if (en && cnt_r == CNT_LAST) begin
               cnt_s   = 8'd0;
               trans_s = 1'b1;
               if (phase < PHASE_LAST) begin
                  phase_s = phase + 4'd1;
               end else begin
                  state_s = DRAIN;
                  phase_s = 4'd0;
               end
            end else if (en) begin
               cnt_s = cnt_r + 8'd1;
            end else begin
               cnt_s = cnt_r;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_s = IDLE;
               cnt_s   = 8'd0;
            end else if (en && cnt_r == CNT_LAST) begin
               state_s = IDLE;
               cnt_s   = 8'd0;
               oe_s    = 1'b1;
            end else if (en) begin
               cnt_s = cnt_r + 8'd1;
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            phase_s = 4'd0;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      ready_s = (state_s == IDLE);
      if (state_s == RUN) begin
         dir_s = base_pattern(phase_s) ^ {DIR_W{desc_s}};
      end else begin
         dir_s = {DIR_W{1'b0}};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= 8'd0;
         desc_r        <= 1'b0;
         phase         <= 4'd0;
         direction     <= {DIR_W{1'b0}};
         trans         <= 1'b0;
         output_enable <= 1'b0;
         ready         <= 1'b1;
         busy          <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         desc_r        <= desc_s;
         phase         <= phase_s;
         direction     <= dir_s;
         trans         <= trans_s;
         output_enable <= oe_s;
         ready         <= ready_s;
         busy          <= !ready_s;
      end
   end

endmodule

// File: tb/tb_mdsa_phase_sequencer.sv
// Directed bench for mdsa_phase_sequencer with default parameters.
// Edge numbering is relative to the edge that accepts start (edge 0).
module tb_mdsa_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       start = 1'b0;
   logic       descend = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] direction;
   logic [3:0] phase;
   logic       ready, busy, trans, output_enable;

   int checks = 0;
   int errors = 0;

   mdsa_phase_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .descend(descend), .abort(abort),
      .direction(direction), .phase(phase), .ready(ready), .busy(busy),
      .trans(trans), .output_enable(output_enable)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected phase after k enabled cycles of a run (k = 0 is the start edge).
   function automatic int exp_phase(input int k);
      if (k < 60) return k / 10 + 1;
      else return 0;
   endfunction

   function automatic logic [7:0] exp_dir(input int p, input logic d);
      logic [7:0] b;
      if (p == 0) return 8'h00;
      if (p % 4 == 2) b = 8'h55;
      else if (p % 4 == 0) b = 8'hAA;
      else b = 8'h00;
      return d ? ~b : b;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({ready, busy, trans, output_enable} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags got rdy/busy/tr/oe=%b want 1000", {ready, busy, trans, output_enable});
      end
      checks++;
      if (phase !== 4'd0 || direction !== 8'h00) begin
         errors++;
         $display("FAIL reset_phase_dir got phase=%0d dir=%h want 0/00", phase, direction);
      end
   endtask

   task automatic test_ascend();
      int ep;
      logic et, eo, er;
      descend = 1'b0;
      start = 1'b1;
      for (int e = 0; e <= 71; e++) begin
         step();
         if (e == 0) start = 1'b0;
         ep = (e >= 70) ? 0 : exp_phase(e);
         et = (e <= 60) && (e % 10 == 0);
         eo = (e == 70);
         er = (e >= 70);
         checks++;
         if (phase !== 4'(ep) || direction !== exp_dir(ep, 1'b0)) begin
            errors++;
            $display("FAIL asc_phase_dir e=%0d got %0d/%h want %0d/%h", e, phase, direction, ep, exp_dir(ep, 1'b0));
         end
         checks++;
         if (trans !== et || output_enable !== eo || ready !== er || busy !== !er) begin
            errors++;
            $display("FAIL asc_flags e=%0d got tr/oe/rdy/busy=%b%b%b%b want %b%b%b%b",
                     e, trans, output_enable, ready, busy, et, eo, er, !er);
         end
      end
   endtask

   task automatic test_descend();
      descend = 1'b1;
      start = 1'b1;
      for (int e = 0; e <= 25; e++) begin
         if (e == 5) descend = 1'b0;
         if (e == 15) descend = 1'b1;
         step();
         if (e == 0) start = 1'b0;
         checks++;
         if (phase !== 4'(exp_phase(e)) || direction !== exp_dir(exp_phase(e), 1'b1)) begin
            errors++;
            $display("FAIL desc_dir e=%0d got %0d/%h want %0d/%h", e, phase, direction,
                     exp_phase(e), exp_dir(exp_phase(e), 1'b1));
         end
      end
      descend = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL desc_abort_ready got %b want 1", ready);
      end
   endtask

   task automatic test_en_stall();
      int k = 0;
      int ntr = 0;
      int noe = 0;
      int ep;
      logic used;
      start = 1'b1;
      for (int e = 0; e <= 76; e++) begin
         en = !(e >= 23 && e <= 27);
         used = en;
         step();
         if (e == 0) start = 1'b0;
         if (e > 0 && used) k++;
         ep = (k >= 70) ? 0 : exp_phase(k);
         if (trans === 1'b1) ntr++;
         if (output_enable === 1'b1) noe++;
         checks++;
         if (phase !== 4'(ep)) begin
            errors++;
            $display("FAIL stall_phase e=%0d got %0d want %0d", e, phase, ep);
         end
         checks++;
         if (trans !== (used && k <= 60 && k % 10 == 0)) begin
            errors++;
            $display("FAIL stall_trans e=%0d got %b", e, trans);
         end
         checks++;
         if (output_enable !== (e == 75)) begin
            errors++;
            $display("FAIL stall_oe e=%0d got %b want %b", e, output_enable, e == 75);
         end
      end
      en = 1'b1;
      checks++;
      if (ntr != 7 || noe != 1) begin
         errors++;
         $display("FAIL stall_pulse_count got trans=%0d oe=%0d want 7/1", ntr, noe);
      end
   endtask

   task automatic test_abort();
      int noe = 0;
      start = 1'b1;
      for (int e = 0; e <= 25; e++) begin
         step();
         if (e == 0) start = 1'b0;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({ready, busy, trans, output_enable} !== 4'b1000 || phase !== 4'd0 || direction !== 8'h00) begin
         errors++;
         $display("FAIL abort_idle got rdy/busy/tr/oe=%b phase=%0d dir=%h want 1000/0/00",
                  {ready, busy, trans, output_enable}, phase, direction);
      end
      for (int i = 0; i < 80; i++) begin
         step();
         if (output_enable !== 1'b0 || ready !== 1'b1) noe++;
      end
      checks++;
      if (noe != 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d bad cycles want 0", noe);
      end
   endtask

   task automatic test_start_held();
      int bad = 0;
      start = 1'b1;
      for (int e = 0; e <= 69; e++) begin
         step();
         if (trans !== ((e <= 60) && (e % 10 == 0)) || busy !== 1'b1 || phase !== 4'(exp_phase(e))) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL held_run got %0d bad cycles want 0", bad);
      end
      step();
      checks++;
      if (output_enable !== 1'b1 || ready !== 1'b1 || trans !== 1'b0) begin
         errors++;
         $display("FAIL held_oe got oe/rdy/tr=%b%b%b want 110", output_enable, ready, trans);
      end
      step();
      checks++;
      if (trans !== 1'b1 || phase !== 4'd1 || busy !== 1'b1 || output_enable !== 1'b0) begin
         errors++;
         $display("FAIL held_restart got tr=%b phase=%0d busy=%b oe=%b want 1/1/1/0",
                  trans, phase, busy, output_enable);
      end
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_rst_mid();
      int noe = 0;
      start = 1'b1;
      for (int e = 0; e <= 40; e++) begin
         step();
         if (e == 0) start = 1'b0;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({ready, busy, trans, output_enable} !== 4'b1000 || phase !== 4'd0 || direction !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid got rdy/busy/tr/oe=%b phase=%0d dir=%h want 1000/0/00",
                  {ready, busy, trans, output_enable}, phase, direction);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (trans !== 1'b1 || phase !== 4'd1 || busy !== 1'b1 || direction !== 8'h00) begin
         errors++;
         $display("FAIL rst_restart got tr=%b phase=%0d busy=%b dir=%h want 1/1/1/00",
                  trans, phase, busy, direction);
      end
      for (int e = 1; e <= 71; e++) begin
         step();
         if (output_enable === 1'b1 && e != 70) noe++;
         if (e == 10) begin
            checks++;
            if (direction !== 8'h55) begin
               errors++;
               $display("FAIL rst_run_dir got %h want 55", direction);
            end
         end
         if (e == 70) begin
            checks++;
            if (output_enable !== 1'b1) begin
               errors++;
               $display("FAIL rst_run_oe got %b want 1", output_enable);
            end
         end
      end
      checks++;
      if (noe != 0) begin
         errors++;
         $display("FAIL rst_run_stray_oe got %0d want 0", noe);
      end
   endtask

   initial begin
      test_reset();
      test_ascend();
      test_descend();
      test_en_stall();
      test_abort();
      test_start_held();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
